pcoder_stream: RTL and testbench

- Parametrised, sequential successor to the 8-to-3 combinational priority encoder.
- Captures an N-bit request vector through a valid/ready input handshake.
- Emits the index of every set bit, one per output handshake, highest index first, with a last-beat marker and a population count.
- Sits between request-collecting logic and any consumer that must service every asserted request, not only the highest.

---
 rtl/pcoder_stream.sv | 172 +++++++++++++++++
 tb/tb_pcoder_stream.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcoder_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pcoder_stream
//  Purpose  : Streaming priority encoder. Captures an N-bit request vector
//             through a valid/ready handshake, then emits the index of every
//             set bit, one per output handshake, together with a last-beat
//             marker, an all-zero flag and the population count.
//             Default order is highest index first.
//  Option   : `define PCODER_STREAM_LSB_FIRST_EN to emit the lowest set index
//             first; code_last_o then marks the highest set bit.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1     clock, rising edge
//    rst_n         in   1     asynchronous active-low reset
//    in_valid_i    in   1     request vector valid
//    in_ready_o    out  1     block can accept a vector (IDLE)
//    in_i          in   N     request vector, sampled only on accept
//    code_valid_o  out  1     code beat valid (DRAIN)
//    code_ready_i  in   1     consumer accepts the code beat
//    code_o        out  W     index of the current set bit
//    code_last_o   out  1     current beat is the final one for the vector
//    code_none_o   out  1     captured vector was all zeros
//    code_cnt_o    out  W+1   number of set bits in the captured vector
// ============================================================================
module pcoder_stream #(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [N-1:0] in_i,
   output logic         code_valid_o,
   input  logic         code_ready_i,
   output logic [W-1:0] code_o,
   output logic         code_last_o,
   output logic         code_none_o,
   output logic [W:0]   code_cnt_o
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

   state_t         state_q,   state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [W:0]     cnt_q,     cnt_d;
   logic           none_q,    none_d;

   logic [W:0]     w_popcnt;
   logic [W-1:0]   w_sel;
   logic [N-1:0]   w_sel_mask;
   logic           w_multi;

   // ------------------------------------------------------------------------
   // Population count of the incoming vector, only used on the accept cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < N; i++) begin
         w_popcnt = w_popcnt + {{W{1'b0}}, in_i[i]};
      end
   end

   // ------------------------------------------------------------------------
   // Priority select on the pending bits. The loop direction decides which
   // set bit wins: the last match in loop order overrides earlier ones.
   // An empty pending vector selects index 0 (the zero-vector beat).
   // ------------------------------------------------------------------------
   always_comb begin
      w_sel = '0;
`ifdef PCODER_STREAM_LSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            w_sel = W'(i);
         end
      end
`else
      for (int i = 0; i < N; i++) begin
         if (pending_q[i]) begin
            w_sel = W'(i);
         end
      end
`endif
   end

   // One-hot mask of the selected bit, used to retire it on a handshake.
   always_comb begin
      w_sel_mask = '0;
      for (int i = 0; i < N; i++) begin
         w_sel_mask[i] = (w_sel == W'(i));
      end
   end

   // x & (x-1) clears the lowest set bit; a non-zero result means two or more
   // bits remain, so the current beat is not the last one.
   assign w_multi = |(pending_q & (pending_q - c_one));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      none_d    = none_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               pending_d = in_i;
               cnt_d     = w_popcnt;
               none_d    = (in_i == '0);
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (code_ready_i) begin
               if (!w_multi) begin
                  // Final beat: drop back to IDLE with summary outputs cleared.
                  state_d   = ST_IDLE;
                  pending_d = '0;
                  cnt_d     = '0;
                  none_d    = 1'b0;
               end else begin
                  pending_d = pending_q & ~w_sel_mask;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pending_d = '0;
            cnt_d     = '0;
            none_d    = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         cnt_q     <= '0;
         none_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         none_q    <= none_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: functions of registered state only, never of in_i/code_ready_i.
   // ------------------------------------------------------------------------
   assign in_ready_o   = (state_q == ST_IDLE);
   assign code_valid_o = (state_q == ST_DRAIN);
   assign code_o       = (state_q == ST_DRAIN) ? w_sel : '0;
   assign code_last_o  = (state_q == ST_DRAIN) && !w_multi;
   assign code_none_o  = none_q;
   assign code_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcoder_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pcoder_stream
//  Purpose  : Self-checking bench for pcoder_stream. A driver issues vectors
//             and pushes the expected beat list into a queue; a monitor on the
//             falling edge compares every output cycle against the queue head.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pcoder_stream;

   localparam int N = 8;
   localparam int W = $clog2(N);

   logic         clk;
   logic         rst_n;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [N-1:0] in_i;
   logic         code_valid_o;
   logic         code_ready_i;
   logic [W-1:0] code_o;
   logic         code_last_o;
   logic         code_none_o;
   logic [W:0]   code_cnt_o;

   pcoder_stream #(.N(N)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .in_i         (in_i),
      .code_valid_o (code_valid_o),
      .code_ready_i (code_ready_i),
      .code_o       (code_o),
      .code_last_o  (code_last_o),
      .code_none_o  (code_none_o),
      .code_cnt_o   (code_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int code;
      bit last;
      bit none;
      int cnt;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp    = 0;
   int    n_err    = 0;
   bit    in_reset = 1'b1;
   int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the beats a vector must produce, from the bit list.
   function automatic void push_expected(input logic [N-1:0] v);
      int    pc;
      int    k;
      int    idx;
      beat_t b;
      pc = $countones(v);
      if (pc == 0) begin
         b.code = 0; b.last = 1'b1; b.none = 1'b1; b.cnt = 0;
         exp_q.push_back(b);
      end else begin
         k = 0;
         for (int j = 0; j < N; j++) begin
`ifdef PCODER_STREAM_LSB_FIRST_EN
            idx = j;
`else
            idx = N - 1 - j;
`endif
            if (v[idx]) begin
               k++;
               b.code = idx; b.last = (k == pc); b.none = 1'b0; b.cnt = pc;
               exp_q.push_back(b);
            end
         end
      end
   endfunction

   // Monitor: output state must always match the head of the expected queue.
   always @(negedge clk) begin
      if (!in_reset) begin
         check("code_valid", {31'd0, code_valid_o}, {31'd0, exp_q.size() != 0});
         check("in_ready",   {31'd0, in_ready_o},   {31'd0, exp_q.size() == 0});
         if (exp_q.size() != 0) begin
            check("code",      32'(code_o),      32'(exp_q[0].code));
            check("code_last", 32'(code_last_o), 32'(exp_q[0].last));
            check("code_none", 32'(code_none_o), 32'(exp_q[0].none));
            check("code_cnt",  32'(code_cnt_o),  32'(exp_q[0].cnt));
            if (code_ready_i) begin
               void'(exp_q.pop_front());
            end
         end else begin
            check("idle_code", 32'(code_o),      32'd0);
            check("idle_last", 32'(code_last_o), 32'd0);
            check("idle_none", 32'(code_none_o), 32'd0);
            check("idle_cnt",  32'(code_cnt_o),  32'd0);
         end
      end
   end

   // Consumer ready generator, updated just after each rising edge.
   initial begin
      code_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       code_ready_i = 1'b1;
            1:       code_ready_i = ($urandom % 3) != 0;
            default: code_ready_i = 1'b0;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the accept edge.
   task automatic send(input logic [N-1:0] v);
      int t;
      t = 0;
      while (!in_ready_o && t < 1000) begin
         step();
         t++;
      end
      if (!in_ready_o) begin
         check("accept_timeout", 32'd0, 32'd1);
         return;
      end
      in_valid_i = 1'b1;
      in_i       = v;
      step();
      push_expected(v);
      in_valid_i = 1'b0;
      in_i       = N'($urandom);
   endtask

   task automatic wait_empty();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         step();
         t++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      logic [N-1:0] v;
      rst_n      = 1'b0;
      in_valid_i = 1'b0;
      in_i       = '0;

      // Reset held for 3 cycles: idle outputs throughout.
      repeat (3) begin
         @(negedge clk);
         check("rst_in_ready",   {31'd0, in_ready_o},   32'd1);
         check("rst_code_valid", {31'd0, code_valid_o}, 32'd0);
         check("rst_code",       32'(code_o),           32'd0);
         check("rst_code_cnt",   32'(code_cnt_o),       32'd0);
      end
      #1;
      rst_n    = 1'b1;
      in_reset = 1'b0;
      repeat (2) step();

      // Multi-bit drain at full throughput.
      rdy_mode = 0;
      send(N'(8'hA5));
      wait_empty();
      step();

      // Backpressure: stalled for 3 cycles, input changes have no effect.
      rdy_mode = 2;
      send(N'(8'h81));
      in_i = N'(8'hFF);
      repeat (3) begin
         @(negedge clk);
`ifdef PCODER_STREAM_LSB_FIRST_EN
         check("bp_hold_code", 32'(code_o), 32'd0);
`else
         check("bp_hold_code", 32'(code_o), 32'(N - 1));
`endif
         check("bp_hold_cnt", 32'(code_cnt_o), 32'd2);
         #1;
      end
      step();
      rdy_mode = 0;
      wait_empty();

      // Single-hot sweep, zero vector, all-ones vector.
      for (int i = 0; i < N; i++) begin
         v    = '0;
         v[i] = 1'b1;
         send(v);
      end
      send('0);
      send('1);
      wait_empty();

      // Randomized vectors under random backpressure and random gaps.
      rdy_mode = 1;
      for (int n = 0; n < 150; n++) begin
         case ($urandom % 4)
            0:       v = '0;
            1: begin
               v = '0;
               v[$urandom % N] = 1'b1;
            end
            default: v = N'($urandom);
         endcase
         send(v);
         repeat ($urandom % 3) step();
      end
      wait_empty();

      // Reset in the middle of a drain.
      rdy_mode = 0;
      step();
      send('1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      in_reset = 1'b1;
      rst_n    = 1'b0;
      #1;
      check("mid_rst_code_valid", {31'd0, code_valid_o}, 32'd0);
      check("mid_rst_in_ready",   {31'd0, in_ready_o},   32'd1);
      check("mid_rst_code_cnt",   32'(code_cnt_o),       32'd0);
      check("mid_rst_code_none",  {31'd0, code_none_o},  32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1;
      rst_n    = 1'b1;
      in_reset = 1'b0;
      step();
      repeat (2) step();
      send(N'(8'h04));
      wait_empty();
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
